// File: rtl/msix_vec_ctrl.sv
// MSI-X vector table, pending-bit array and round-robin request issue.
// Optional MSIX_VEC_CTRL_STAT_EN adds issue/coalesce statistics counters.
module msix_vec_ctrl #(
  parameter int VEC_NUM = 8,
  parameter int VEC_W   = 3
) (
  input  logic               pcie_clk,
  input  logic               pcie_rst_n,
  input  logic               vec_req_valid,
  input  logic [VEC_W-1:0]   vec_req_idx,
  output logic               vec_req_ready,
  input  logic               tbl_wen,
  input  logic [VEC_W+1:0]   tbl_waddr,
  input  logic [31:0]        tbl_wdata,
  input  logic               tbl_ren,
  input  logic [VEC_W+1:0]   tbl_raddr,
  output logic [31:0]        tbl_rdata,
  output logic [VEC_NUM-1:0] pba_rdata,
  input  logic               msix_enable,
  input  logic               func_mask,
  output logic               int_req_valid,
  output logic [63:0]        int_req_addr,
  output logic [31:0]        int_req_data,
`ifdef MSIX_VEC_CTRL_STAT_EN
  output logic [31:0]        stat_issue_cnt,
  output logic [31:0]        stat_coal_cnt,
`endif
  input  logic               int_req_ready
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ISSUE
  } state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   ptr_q, ptr_d;
  logic [VEC_W-1:0]   gidx_q, gidx_d;
  logic [VEC_NUM-1:0] pba_q, pba_d;
  logic [VEC_NUM-1:0] mask_q;
  logic [31:0]        alo_q [VEC_NUM];
  logic [31:0]        ahi_q [VEC_NUM];
  logic [31:0]        dat_q [VEC_NUM];
  logic [31:0]        rdata_q, rdata_d;
  logic [63:0]        addr_q;
  logic [31:0]        data_q;

  logic [VEC_NUM-1:0] elig;
  logic [VEC_W-1:0]   cand;
  logic [VEC_W-1:0]   gnt;
  logic               found;
  logic               load;
  logic               hs;

  logic [VEC_W-1:0]   wvec, rvec;
  logic [1:0]         wdw, rdw;

  assign wvec = tbl_waddr[VEC_W+1:2];
  assign wdw  = tbl_waddr[1:0];
  assign rvec = tbl_raddr[VEC_W+1:2];
  assign rdw  = tbl_raddr[1:0];

  assign vec_req_ready = 1'b1;
  assign tbl_rdata     = rdata_q;
  assign pba_rdata     = pba_q;
  assign int_req_valid = (state_q == ISSUE);
  assign int_req_addr  = addr_q;
  assign int_req_data  = data_q;

  assign elig = pba_q & ~mask_q &
                {VEC_NUM{msix_enable & ~func_mask}};

  // First eligible vector at or above ptr, wrapping
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int i = 0; i < VEC_NUM; i++) begin
      cand = ptr_q + VEC_W'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    load    = 1'b0;
    hs      = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gidx_d  = gnt;
          ptr_d   = gnt + 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (int_req_ready) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle event beats the handshake clear
  always_comb begin
    pba_d = pba_q;
    if (hs) pba_d[gidx_q] = 1'b0;
    if (vec_req_valid) pba_d[vec_req_idx] = 1'b1;
  end

  always_comb begin
    rdata_d = '0;
    case (rdw)
      2'd0:    rdata_d = alo_q[rvec];
      2'd1:    rdata_d = ahi_q[rvec];
      2'd2:    rdata_d = dat_q[rvec];
      default: rdata_d = {31'b0, mask_q[rvec]};
    endcase
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      pba_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      pba_q   <= pba_d;
      if (tbl_ren) rdata_q <= rdata_d;
      if (load) begin
        addr_q <= {ahi_q[gidx_q], alo_q[gidx_q]};
        data_q <= dat_q[gidx_q];
      end
    end
  end

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      mask_q <= '1;
      for (int i = 0; i < VEC_NUM; i++) begin
        alo_q[i] <= '0;
        ahi_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else if (tbl_wen) begin
      case (wdw)
        2'd0:    alo_q[wvec]  <= tbl_wdata;
        2'd1:    ahi_q[wvec]  <= tbl_wdata;
        2'd2:    dat_q[wvec]  <= tbl_wdata;
        default: mask_q[wvec] <= tbl_wdata[0];
      endcase
    end
  end

`ifdef MSIX_VEC_CTRL_STAT_EN
  logic [31:0] issue_q;
  logic [31:0] coal_q;

  assign stat_issue_cnt = issue_q;
  assign stat_coal_cnt  = coal_q;

  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      issue_q <= '0;
      coal_q  <= '0;
    end else begin
      if (hs && !(&issue_q)) issue_q <= issue_q + 32'd1;
      if (vec_req_valid && pba_q[vec_req_idx] && !(&coal_q))
        coal_q <= coal_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msix_vec_ctrl.sv
// Directed self-checking bench for msix_vec_ctrl.
// Define MSIX_VEC_CTRL_STAT_EN to also cover the statistics counters.
module tb_msix_vec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vreq_v = 1'b0;
  logic [2:0]  vreq_i = '0;
  logic        vreq_r;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        ren = 1'b0;
  logic [4:0]  raddr = '0;
  logic [31:0] rdata;
  logic [7:0]  pba;
  logic        en = 1'b0;
  logic        fmask = 1'b0;
  logic        iv;
  logic [63:0] ia;
  logic [31:0] id;
  logic        ir = 1'b1;
`ifdef MSIX_VEC_CTRL_STAT_EN
  logic [31:0] s_iss;
  logic [31:0] s_coal;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  msix_vec_ctrl dut (
    .pcie_clk      (clk),
    .pcie_rst_n    (rst_n),
    .vec_req_valid (vreq_v),
    .vec_req_idx   (vreq_i),
    .vec_req_ready (vreq_r),
    .tbl_wen       (wen),
    .tbl_waddr     (waddr),
    .tbl_wdata     (wdata),
    .tbl_ren       (ren),
    .tbl_raddr     (raddr),
    .tbl_rdata     (rdata),
    .pba_rdata     (pba),
    .msix_enable   (en),
    .func_mask     (fmask),
    .int_req_valid (iv),
    .int_req_addr  (ia),
    .int_req_data  (id),
`ifdef MSIX_VEC_CTRL_STAT_EN
    .stat_issue_cnt(s_iss),
    .stat_coal_cnt (s_coal),
`endif
    .int_req_ready (ir)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic wr(input int v, input int dw, input logic [31:0] d);
    wen   = 1'b1;
    waddr = 5'(v * 4 + dw);
    wdata = d;
    tick();
    wen   = 1'b0;
  endtask

  task automatic rd(input int v, input int dw, output logic [31:0] d);
    ren   = 1'b1;
    raddr = 5'(v * 4 + dw);
    tick();
    ren   = 1'b0;
    d     = rdata;
  endtask

  task automatic ev(input int v);
    vreq_v = 1'b1;
    vreq_i = 3'(v);
    tick();
    vreq_v = 1'b0;
  endtask

  task automatic wait_v(input string tag);
    int n;
    n = 0;
    while (!iv && n < 20) begin
      tick();
      n++;
    end
    if (!iv) chk(tag, 64'd0, 64'd1);
  endtask

  logic [31:0] r;
  logic [31:0] got [3];

  initial begin
    do_reset();
    chk("rst_valid", 64'(iv), 64'd0);
    chk("rst_pba", 64'(pba), 64'd0);
    chk("rst_addr", ia, 64'd0);
    chk("rst_data", 64'(id), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("vec_ready", 64'(vreq_r), 64'd1);
    rd(3, 3, r);
    chk("rst_mask3", 64'(r), 64'd1);
    rd(3, 2, r);
    chk("rst_data3", 64'(r), 64'd0);

    // basic issue of vector 2
    en = 1'b1;
    wr(2, 0, 32'hFEE0_0000);
    wr(2, 1, 32'h0000_0001);
    wr(2, 2, 32'h0000_0042);
    wr(2, 3, 32'h0);
    rd(2, 1, r);
    chk("rd_ahi2", 64'(r), 64'd1);
    ev(2);
    chk("t1_pba_set", 64'(pba), 64'h04);
    chk("t1_c1_valid", 64'(iv), 64'd0);
    tick();
    chk("t1_c2_valid", 64'(iv), 64'd0);
    tick();
    chk("t1_c3_valid", 64'(iv), 64'd1);
    chk("t1_addr", ia, 64'h0000_0001_FEE0_0000);
    chk("t1_data", 64'(id), 64'h42);
    tick();
    chk("t1_pba_clr", 64'(pba), 64'd0);
    chk("t1_valid_drop", 64'(iv), 64'd0);

    // round robin 1,3,5 from ptr 0
    do_reset();
    en = 1'b0;
    for (int v = 1; v < 7; v += 2) begin
      wr(v, 2, 32'(v));
      wr(v, 3, 32'h0);
    end
    ev(5);
    ev(3);
    ev(1);
    tick();
    chk("rr_pba", 64'(pba), 64'h2A);
    chk("rr_no_valid", 64'(iv), 64'd0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_v("rr_timeout");
      got[k] = id;
      tick();
    end
    chk("rr_first", 64'(got[0]), 64'd1);
    chk("rr_second", 64'(got[1]), 64'd3);
    chk("rr_third", 64'(got[2]), 64'd5);
    chk("rr_pba_empty", 64'(pba), 64'd0);
    ev(1);
    wait_v("rr_wrap_timeout");
    chk("rr_wrap_data", 64'(id), 64'd1);
    tick();

    // masked vector 4 keeps pending until unmasked
    wr(4, 2, 32'h44);
    ev(4);
    repeat (5) tick();
    chk("m4_no_valid", 64'(iv), 64'd0);
    chk("m4_pba", 64'(pba), 64'h10);
    wr(4, 3, 32'h0);
    chk("m4_c1", 64'(iv), 64'd0);
    tick();
    chk("m4_c2", 64'(iv), 64'd0);
    tick();
    chk("m4_c3", 64'(iv), 64'd1);
    chk("m4_data", 64'(id), 64'h44);
    tick();
    chk("m4_pba_clr", 64'(pba), 64'd0);

    // stall on vector 6, rewrite data, re-raise at handshake
    wr(6, 2, 32'h66);
    wr(6, 3, 32'h0);
    ir = 1'b0;
    ev(6);
    tick();
    tick();
    chk("v6_valid", 64'(iv), 64'd1);
    chk("v6_data", 64'(id), 64'h66);
    wr(6, 2, 32'h99);
    tick();
    chk("v6_held", 64'(iv), 64'd1);
    chk("v6_data_stable", 64'(id), 64'h66);
    ir     = 1'b1;
    vreq_v = 1'b1;
    vreq_i = 3'd6;
    tick();
    vreq_v = 1'b0;
    chk("v6_idle", 64'(iv), 64'd0);
    chk("v6_pba_kept", 64'(pba), 64'h40);
    wait_v("v6_reissue_timeout");
    chk("v6_new_data", 64'(id), 64'h99);
    tick();
    chk("v6_pba_clr", 64'(pba), 64'd0);

    // function mask holds three pending vectors
    fmask = 1'b1;
    ev(1);
    ev(3);
    ev(5);
    repeat (4) tick();
    chk("fm_no_valid", 64'(iv), 64'd0);
    chk("fm_pba", 64'(pba), 64'h2A);
    fmask = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_v("fm_timeout");
      got[k] = id;
      tick();
    end
    chk("fm_sum", 64'(got[0] + got[1] + got[2]), 64'd9);
    chk("fm_pba_empty", 64'(pba), 64'd0);

`ifdef MSIX_VEC_CTRL_STAT_EN
    do_reset();
    wr(4, 2, 32'h44);
    repeat (4) ev(4);
    tick();
    chk("st_coal", 64'(s_coal), 64'd3);
    chk("st_iss0", 64'(s_iss), 64'd0);
    wr(4, 3, 32'h0);
    wait_v("st_timeout");
    tick();
    chk("st_iss1", 64'(s_iss), 64'd1);
    chk("st_pba", 64'(pba), 64'd0);
`endif

    // asynchronous reset while requesting
    wr(2, 2, 32'h22);
    wr(2, 3, 32'h0);
    ir = 1'b0;
    ev(2);
    wait_v("ar_timeout");
    chk("ar_valid_pre", 64'(iv), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", 64'(iv), 64'd0);
    chk("ar_pba", 64'(pba), 64'd0);
    ir = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ar_pba_after", 64'(pba), 64'd0);
    chk("ar_valid_after", 64'(iv), 64'd0);
    rd(2, 3, r);
    chk("ar_mask2", 64'(r), 64'd1);
    rd(2, 2, r);
    chk("ar_data2", 64'(r), 64'd0);

    // same-dword write and read returns old value
    wen   = 1'b1;
    waddr = 5'd9;
    wdata = 32'hABCD;
    ren   = 1'b1;
    raddr = 5'd9;
    tick();
    wen = 1'b0;
    ren = 1'b0;
    chk("rw_old", 64'(rdata), 64'd0);
    tick();
    chk("rw_hold", 64'(rdata), 64'd0);
    rd(2, 1, r);
    chk("rw_new", 64'(r), 64'hABCD);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/msix_vec_ctrl.md
# msix_vec_ctrl

Per-vector MSI-X source stage in the pcie_clk domain, directly upstream of the interrupt processor. It holds the MSI-X vector table and the pending-bit array, and coalesces interrupt events raised by vector index. It selects eligible vectors round-robin and presents each one as an {address, data} request on the int_req valid/ready interface, which feeds the interrupt CDC FIFO and the cfg_interrupt_msix_* sender.

## Interface
- VEC_NUM, 8: number of MSI-X vectors (power of two, 2..32)
- VEC_W, 3: log2(VEC_NUM)
- pcie_clk  in  1  block clock
- pcie_rst_n  in  1  reset: pcie_rst_n, asynchronous, active-low; clock pcie_clk
- vec_req_valid  in  1  event on a vector
- vec_req_idx  in  VEC_W  vector index of the event
- vec_req_ready  out  1  tied 1 (events always accepted)
- tbl_wen  in  1  table dword write strobe
- tbl_waddr  in  VEC_W+2  {vector, dword}; dword 0 = addr_lo, 1 = addr_hi, 2 = data, 3 = ctrl (bit0 = mask)
- tbl_wdata  in  32  write data
- tbl_ren  in  1  table dword read strobe
- tbl_raddr  in  VEC_W+2  read address, same map as tbl_waddr
- tbl_rdata  out  32  registered read data; ctrl dword reads as {31'b0, mask}
- pba_rdata  out  VEC_NUM  pending-bit array, direct register output
- msix_enable  in  1  MSI-X enable (cfg_interrupt_msix_enable[0])
- func_mask  in  1  function mask (cfg_interrupt_msix_mask[0])
- int_req_valid  out  1  interrupt request valid
- int_req_addr  out  64  message address
- int_req_data  out  32  message data
- int_req_ready  in  1  downstream accept

## Operation
- Reset values: all addr/data entries 0, all mask bits 1, pba 0, tbl_rdata 0, int_req_valid 0, int_req_addr/int_req_data 0, state IDLE, round-robin pointer 0.
- An accepted event sets pba[vec_req_idx]. Events on a vector that is already pending coalesce into the existing pending bit.
- A vector is eligible when pba[i] & ~mask[i] & msix_enable & ~func_mask.
- FSM:
  - IDLE: if any vector is eligible, grant the first eligible index searching from ptr upward with wrap-around, latch grant_idx, set ptr = grant_idx+1 (mod VEC_NUM), go to LOAD.
  - LOAD: latch the table addr/data for grant_idx into the int_req_* registers, go to ISSUE.
  - ISSUE: hold int_req_valid=1 with stable addr/data. On int_req_valid & int_req_ready, clear pba[grant_idx] and go to IDLE.
- Mask bits, msix_enable and func_mask are evaluated only in IDLE. A vector already in LOAD or ISSUE completes its issue even if it is masked or disabled afterwards. Gating after that point is the downstream block's job.
- A table write to the in-flight vector during LOAD or ISSUE does not change the latched int_req_addr/int_req_data. The write updates the table only.
- If an event arrives on grant_idx in the same cycle as the handshake, the set wins and pba[grant_idx] stays 1, so the vector is issued again later.
- A masked or disabled vector keeps its pending bit. It is issued once it becomes eligible.
- If tbl_wen and tbl_ren target the same dword in the same cycle, the read returns the old value.
- Reset asserted mid-operation drops int_req_valid immediately and loses all pending and table state.

## Timing
- Event sampled in cycle 0 → pba bit set from cycle 1 → IDLE grants in cycle 1 → LOAD in cycle 2 → int_req_valid=1 in cycle 3, assuming the vector is eligible and the FSM is idle.
- A handshake in cycle N puts the FSM in IDLE in cycle N+1. Minimum spacing is 3 cycles per interrupt.
- tbl_rdata is valid the cycle after tbl_ren and holds until the next tbl_ren.
- pba_rdata reflects a set or clear one cycle after the causing edge.

## Configuration
- MSIX_VEC_CTRL_STAT_EN defined:
  - Adds two outputs: stat_issue_cnt [31:0] counts int_req handshakes; stat_coal_cnt [31:0] counts events accepted while the target pba bit is already 1.
  - Both counters reset to 0 and saturate at 0xFFFF_FFFF.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Program vector 2: addr 0x0000_0001_FEE0_0000, data 0x0000_0042, mask 0; msix_enable=1; event on idx 2 in cycle 0 → int_req_valid in cycle 3 with that addr/data; ready=1 → pba[2]=0 next cycle.
- Vectors 1, 3 and 5 all pending and unmasked, ptr=0, ready always 1 → issue order 1, 3, 5. A new event on 1 after that → 1 is issued next, after the pointer wraps.
- Vector 4 masked, event on 4 → no int_req_valid and pba[4]=1. Write mask=0 → int_req_valid 3 cycles later, then pba[4]=0.
- Hold ready=0 in ISSUE for vector 6 while writing new data 0x99 to vector 6 and raising an event on 6 → int_req_data stays at the old value. On handshake pba[6] stays 1 and a second issue follows with data 0x99.
- func_mask=1 with three vectors pending → no request. Clear func_mask → all three issued. With STAT_EN, repeat 4 events on one vector while it is masked → stat_coal_cnt=3 and stat_issue_cnt +1 after unmask.
- Assert pcie_rst_n low while int_req_valid=1 → valid=0 asynchronously. After release, all masks=1, pba=0, and tbl_rdata of ctrl dword = 0x1.
